clause_interval_collector: RTL and testbench

- Consumer of the per-clause ReduceClause result stream. ReduceClause emits one reduced clause per cycle in the form (+/-)y + b <= 0 for the variable being resampled.
- This block accepts those clauses under a valid/ready handshake and intersects them into a single feasible interval [lower, upper] for that variable.
- It then flags whether the interval is non-empty. The downstream sampler draws the new value of y from that interval.

---
 rtl/clause_interval_collector_pkg.sv | 22 ++
 rtl/clause_interval_collector_bound_update.sv | 44 ++++
 rtl/clause_interval_collector.sv | 107 ++++++++++
 tb/tb_clause_interval_collector.sv | 245 ++++++++++++++++++++++++
 4 files changed

// File: rtl/clause_interval_collector_pkg.sv
// Shared definitions for the clause interval collector: widths, FSM state
// encoding and the full-range bound constants used on every new variable.
// Ports: none (package).
package clause_interval_collector_pkg;

    localparam int MAXIMUM_BIT_WIDTH_OF_COEFFICIENT  = 8;
    localparam int MAXIMUM_BIT_WIDTH_OF_CLAUSE_COUNT = 4;

    localparam int W  = MAXIMUM_BIT_WIDTH_OF_COEFFICIENT;
    localparam int CW = MAXIMUM_BIT_WIDTH_OF_CLAUSE_COUNT;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_COLLECT = 2'd1,
        ST_DONE    = 2'd2
    } state_t;

    // Widest interval representable in W signed bits.
    localparam logic signed [W-1:0] BOUND_MIN = {1'b1, {(W-1){1'b0}}};
    localparam logic signed [W-1:0] BOUND_MAX = {1'b0, {(W-1){1'b1}}};

endpackage

// File: rtl/clause_interval_collector_bound_update.sv
// Purpose: narrows [lower, upper] by one reduced clause (+/-)y + b <= 0.
// Latency: purely combinational.
// Backpressure: none; the caller decides when the result is committed.
// Ports: i_lower/i_upper current bounds, i_bias/i_sign/i_active clause,
//        o_lower/o_upper narrowed bounds.
module clause_bound_update
    import clause_interval_collector_pkg::*;
(
    input  logic signed [W-1:0] i_lower,
    input  logic signed [W-1:0] i_upper,
    input  logic signed [W-1:0] i_bias,
    input  logic                i_sign,
    input  logic                i_active,
    output logic signed [W-1:0] o_lower,
    output logic signed [W-1:0] o_upper
);

    // -bias needs one extra bit so that bias = -2^(W-1) yields +2^(W-1),
    // which is never below any W-bit upper bound and so leaves it unchanged.
    logic signed [W:0] w_neg_bias;
    logic signed [W:0] w_upper_ext;

    assign w_neg_bias  = -$signed({i_bias[W-1], i_bias});
    assign w_upper_ext = $signed({i_upper[W-1], i_upper});

    always_comb begin
        o_lower = i_lower;
        o_upper = i_upper;
        if (i_active) begin
            if (i_sign) begin
                // +y + b <= 0  ->  y <= -b
                if (w_neg_bias < w_upper_ext) begin
                    o_upper = w_neg_bias[W-1:0];
                end
            end else begin
                // -y + b <= 0  ->  y >= b
                if (i_bias > i_lower) begin
                    o_lower = i_bias;
                end
            end
        end
    end

endmodule

// File: rtl/clause_interval_collector.sv
// Purpose: intersects a stream of reduced clauses into one feasible interval for y.
// Latency: bounds update one cycle after each accept; done one cycle after the last accept.
// Backpressure: ready only in COLLECT; nothing is buffered, upstream holds the clause.
// Ports: in_clk/in_reset_n clock and async active-low reset; in_start begins a
//        new variable; in_clause_valid/out_clause_ready handshake carrying
//        in_bias/in_sign/in_active/in_last; results out_lower_bound,
//        out_upper_bound, out_feasible, out_done, out_active_count.
module clause_interval_collector
    import clause_interval_collector_pkg::*;
(
    input  logic                 in_clk,
    input  logic                 in_reset_n,
    input  logic                 in_start,
    input  logic                 in_clause_valid,
    output logic                 out_clause_ready,
    input  logic signed [W-1:0]  in_bias,
    input  logic                 in_sign,
    input  logic                 in_active,
    input  logic                 in_last,
    output logic signed [W-1:0]  out_lower_bound,
    output logic signed [W-1:0]  out_upper_bound,
    output logic                 out_feasible,
    output logic                 out_done,
    output logic [CW-1:0]        out_active_count
);

    state_t                r_state;
    state_t                w_state_next;
    logic signed [W-1:0]   r_lower;
    logic signed [W-1:0]   r_upper;
    logic                  r_feasible;
    logic                  r_done;
    logic [CW-1:0]         r_count;
    logic                  w_accept;
    logic signed [W-1:0]   w_next_lower;
    logic signed [W-1:0]   w_next_upper;

    // Ready decodes straight from the state register, so it carries no
    // combinational path from any input.
    assign out_clause_ready = (r_state == ST_COLLECT);

    // A clause coinciding with in_start belongs to the previous variable.
    assign w_accept = in_clause_valid && out_clause_ready && !in_start;

    clause_bound_update u_bound_update (
        .i_lower  (r_lower),
        .i_upper  (r_upper),
        .i_bias   (in_bias),
        .i_sign   (in_sign),
        .i_active (in_active),
        .o_lower  (w_next_lower),
        .o_upper  (w_next_upper)
    );

    always_ff @(posedge in_clk or negedge in_reset_n) begin
        if (!in_reset_n) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        if (in_start) begin
            w_state_next = ST_COLLECT;
        end else begin
            case (r_state)
                ST_COLLECT: if (w_accept && in_last) w_state_next = ST_DONE;
                default:    w_state_next = r_state;
            endcase
        end
    end

    always_ff @(posedge in_clk or negedge in_reset_n) begin
        if (!in_reset_n) begin
            r_lower    <= '0;
            r_upper    <= '0;
            r_feasible <= 1'b0;
            r_done     <= 1'b0;
            r_count    <= '0;
        end else if (in_start) begin
            r_lower    <= BOUND_MIN;
            r_upper    <= BOUND_MAX;
            r_feasible <= 1'b0;
            r_done     <= 1'b0;
            r_count    <= '0;
        end else if (w_accept) begin
            r_lower <= w_next_lower;
            r_upper <= w_next_upper;
            if (in_active && (r_count != {CW{1'b1}})) begin
                r_count <= r_count + CW'(1);
            end
            if (in_last) begin
                r_done     <= 1'b1;
                r_feasible <= (w_next_lower <= w_next_upper);
            end
        end
    end

    assign out_lower_bound  = r_lower;
    assign out_upper_bound  = r_upper;
    assign out_feasible     = r_feasible;
    assign out_done         = r_done;
    assign out_active_count = r_count;

endmodule

// File: tb/tb_clause_interval_collector.sv
module tb_clause_interval_collector;

    logic              in_clk;
    logic              in_reset_n;
    logic              in_start;
    logic              in_clause_valid;
    logic              out_clause_ready;
    logic signed [7:0] in_bias;
    logic              in_sign;
    logic              in_active;
    logic              in_last;
    logic signed [7:0] out_lower_bound;
    logic signed [7:0] out_upper_bound;
    logic              out_feasible;
    logic              out_done;
    logic [3:0]        out_active_count;

    int errors = 0;
    int checks = 0;

    // Reference model: interval and counter as plain integers.
    int m_lo = 0;
    int m_hi = 0;
    int m_cnt = 0;
    int m_done = 0;
    int m_feas = 0;

    clause_interval_collector dut (
        .in_clk           (in_clk),
        .in_reset_n       (in_reset_n),
        .in_start         (in_start),
        .in_clause_valid  (in_clause_valid),
        .out_clause_ready (out_clause_ready),
        .in_bias          (in_bias),
        .in_sign          (in_sign),
        .in_active        (in_active),
        .in_last          (in_last),
        .out_lower_bound  (out_lower_bound),
        .out_upper_bound  (out_upper_bound),
        .out_feasible     (out_feasible),
        .out_done         (out_done),
        .out_active_count (out_active_count)
    );

    initial in_clk = 1'b0;
    always #5 in_clk = ~in_clk;

    task automatic check(input string tag, input int obs, input int exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic check_model(input string tag);
        check({tag, ".lower"}, int'(out_lower_bound), m_lo);
        check({tag, ".upper"}, int'(out_upper_bound), m_hi);
        check({tag, ".count"}, int'(out_active_count), m_cnt);
        check({tag, ".done"}, int'(out_done), m_done);
        if (m_done != 0) check({tag, ".feasible"}, int'(out_feasible), m_feas);
    endtask

    task automatic model_clause(input int bias, input int sign, input int active, input int last);
        if (active != 0) begin
            if (sign != 0) begin
                if (-bias < m_hi) m_hi = -bias;
            end else begin
                if (bias > m_lo) m_lo = bias;
            end
            if (m_cnt < 15) m_cnt++;
        end
        if (last != 0) begin
            m_done = 1;
            m_feas = (m_lo <= m_hi) ? 1 : 0;
        end
    endtask

    task automatic do_start(input string tag);
        @(negedge in_clk);
        in_start = 1'b1;
        @(posedge in_clk);
        #1;
        in_start = 1'b0;
        m_lo = -128; m_hi = 127; m_cnt = 0; m_done = 0; m_feas = 0;
        check({tag, ".ready"}, int'(out_clause_ready), 1);
        check_model(tag);
    endtask

    // Presents one clause and holds it until ready; bounded wait.
    task automatic send_clause(input string tag, input int bias, input int sign,
                               input int active, input int last);
        int waited = 0;
        @(negedge in_clk);
        in_clause_valid = 1'b1;
        in_bias   = 8'(bias);
        in_sign   = sign[0];
        in_active = active[0];
        in_last   = last[0];
        while (!out_clause_ready && waited < 50) begin
            @(negedge in_clk);
            waited++;
        end
        if (!out_clause_ready) begin
            check({tag, ".ready_timeout"}, 0, 1);
            in_clause_valid = 1'b0;
        end else begin
            @(posedge in_clk);
            #1;
            in_clause_valid = 1'b0;
            in_last = 1'b0;
            model_clause(bias, sign, active, last);
            check_model(tag);
            if (last != 0) check({tag, ".ready_after_last"}, int'(out_clause_ready), 0);
        end
    endtask

    initial begin
        int n;
        int b;
        in_reset_n = 1'b0;
        in_start = 1'b0;
        in_clause_valid = 1'b0;
        in_bias = '0;
        in_sign = 1'b0;
        in_active = 1'b0;
        in_last = 1'b0;
        #12;
        // Reset state: everything zero.
        check("rst.ready", int'(out_clause_ready), 0);
        check_model("rst");
        check("rst.feasible", int'(out_feasible), 0);
        @(negedge in_clk);
        in_reset_n = 1'b1;

        // 1: single upper clause
        do_start("t1.start");
        send_clause("t1.c0", 2, 1, 1, 1);
        check("t1.upper_lit", int'(out_upper_bound), -2);
        check("t1.feas_lit", int'(out_feasible), 1);

        // 2: two clauses
        do_start("t2.start");
        send_clause("t2.c0", 2, 0, 1, 0);
        send_clause("t2.c1", -5, 1, 1, 1);
        check("t2.lower_lit", int'(out_lower_bound), 2);
        check("t2.upper_lit", int'(out_upper_bound), 5);

        // DONE holds everything even with valid present.
        @(negedge in_clk);
        in_clause_valid = 1'b1; in_bias = 8'sd100; in_sign = 1'b0; in_active = 1'b1; in_last = 1'b1;
        repeat (3) @(posedge in_clk);
        #1;
        in_clause_valid = 1'b0;
        check("done_hold.ready", int'(out_clause_ready), 0);
        check_model("done_hold");

        // 3: empty interval
        do_start("t3.start");
        send_clause("t3.c0", 6, 0, 1, 0);
        send_clause("t3.c1", -3, 1, 1, 1);
        check("t3.feas_lit", int'(out_feasible), 0);

        // 4: boundary biases and an inactive last clause
        do_start("t4.start");
        send_clause("t4.c0", -128, 1, 1, 0);
        check("t4.upper_lit", int'(out_upper_bound), 127);
        send_clause("t4.c1", -128, 0, 1, 0);
        check("t4.lower_lit", int'(out_lower_bound), -128);
        send_clause("t4.c2", 50, 0, 0, 1);
        check("t4.count_lit", int'(out_active_count), 2);

        // 5: valid in IDLE is ignored, then async reset mid-COLLECT
        @(negedge in_clk);
        in_reset_n = 1'b0;
        @(negedge in_clk);
        in_reset_n = 1'b1;
        m_lo = 0; m_hi = 0; m_cnt = 0; m_done = 0; m_feas = 0;
        in_clause_valid = 1'b1; in_bias = 8'sd9; in_sign = 1'b0; in_active = 1'b1; in_last = 1'b0;
        for (int i = 0; i < 3; i++) begin
            @(posedge in_clk);
            #1;
            check("t5.idle_ready", int'(out_clause_ready), 0);
            check_model("t5.idle");
        end
        in_clause_valid = 1'b0;
        do_start("t5.start");
        send_clause("t5.c0", 7, 0, 1, 0);
        @(negedge in_clk);
        #2;
        in_reset_n = 1'b0;
        #1;
        m_lo = 0; m_hi = 0; m_cnt = 0; m_done = 0; m_feas = 0;
        check("t5.arst_ready", int'(out_clause_ready), 0);
        check("t5.arst_feasible", int'(out_feasible), 0);
        check_model("t5.arst");
        @(negedge in_clk);
        in_reset_n = 1'b1;

        // 6: restart mid-COLLECT; clause alongside in_start is dropped
        do_start("t6.start");
        send_clause("t6.c0", 4, 0, 1, 0);
        @(negedge in_clk);
        in_start = 1'b1;
        in_clause_valid = 1'b1; in_bias = 8'sd100; in_sign = 1'b0; in_active = 1'b1; in_last = 1'b1;
        @(posedge in_clk);
        #1;
        in_start = 1'b0;
        in_clause_valid = 1'b0;
        in_last = 1'b0;
        m_lo = -128; m_hi = 127; m_cnt = 0; m_done = 0; m_feas = 0;
        check("t6.ready", int'(out_clause_ready), 1);
        check_model("t6.restart");
        @(posedge in_clk);
        #1;
        check_model("t6.after");

        // Randomized sets, some long enough to saturate the counter.
        for (int s = 0; s < 20; s++) begin
            do_start("rnd.start");
            n = $urandom_range(1, 20);
            for (int k = 0; k < n; k++) begin
                // Idle gaps with valid low must not disturb anything.
                repeat ($urandom_range(0, 2)) begin
                    @(posedge in_clk);
                    #1;
                    check_model("rnd.gap");
                end
                b = int'($urandom_range(0, 255)) - 128;
                send_clause("rnd.c", b, int'($urandom_range(0, 1)),
                            ($urandom_range(0, 4) != 0) ? 1 : 0, (k == n - 1) ? 1 : 0);
            end
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #900000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

endmodule
